// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin arbiter sharing one combinational single-precision multiplier among N_REQ requesters.
// fmul flushes subnormal inputs/results to zero and rounds to nearest-even.
module fmul (
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] result
);
    logic              sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]       prod;
    logic [22:0]       mant;
    logic              guard, sticky, inc;
    logic [23:0]       mant_r;
    logic signed [9:0] exp_s;
    always_comb begin
        sign   = a_in[31] ^ b_in[31];
        a_nan  = (&a_in[30:23]) && (|a_in[22:0]);
        b_nan  = (&b_in[30:23]) && (|b_in[22:0]);
        a_inf  = (&a_in[30:23]) && !(|a_in[22:0]);
        b_inf  = (&b_in[30:23]) && !(|b_in[22:0]);
        a_zero = !(|a_in[30:23]);
        b_zero = !(|b_in[30:23]);
        prod   = 48'({1'b1, a_in[22:0]}) * 48'({1'b1, b_in[22:0]});
        mant   = prod[47] ? prod[46:24] : prod[45:23];
        guard  = prod[47] ? prod[23] : prod[22];
        sticky = prod[47] ? |prod[22:0] : |prod[21:0];
        inc    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + 24'(inc);
        exp_s  = $signed({2'b0, a_in[30:23]}) + $signed({2'b0, b_in[30:23]}) - 10'sd127
               + $signed({9'b0, prod[47]}) + $signed({9'b0, mant_r[23]});
        result = (a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero))) ? 32'h7FC0_0000
               : (a_inf || b_inf)     ? {sign, 8'hFF, 23'b0}
               : (a_zero || b_zero)   ? {sign, 31'b0}
               : (exp_s >= 10'sd255)  ? {sign, 8'hFF, 23'b0}
               : (exp_s <= 10'sd0)    ? {sign, 31'b0}
               : {sign, exp_s[7:0], mant_r[22:0]};
    end
endmodule

module fmul_arbiter #(
    parameter int BIT_W = 32,
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*BIT_W-1:0] req_a,
    input  logic [N_REQ*BIT_W-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [BIT_W-1:0]       rsp_data,
    output logic                   busy,
    output logic [15:0]            op_count
);
    localparam int IW = $clog2(N_REQ);
    logic [IW-1:0]    ptr_q, ptr_d, id_q, id_d, gnt_idx, idx;
    logic             gnt_found, accept, s1_vld_q, s1_vld_d;
    logic [BIT_W-1:0] a_q, a_d, b_q, b_d, a_sel, b_sel, prod, rsp_data_q, rsp_data_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0]      cnt_q, cnt_d;

    // Scan from ptr+1 upward with wrap; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % N_REQ);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
        accept    = gnt_found && !rst;
        req_ready = accept ? N_REQ'(1) << gnt_idx : '0;
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                a_sel = req_a[i*BIT_W +: BIT_W];
                b_sel = req_b[i*BIT_W +: BIT_W];
            end
        end
    end

    fmul u_fmul (
        .a_in  (a_q),
        .b_in  (b_q),
        .result(prod)
    );

    always_comb begin
        ptr_d       = accept ? gnt_idx : ptr_q;
        s1_vld_d    = accept;
        a_d         = accept ? a_sel : a_q;
        b_d         = accept ? b_sel : b_q;
        id_d        = accept ? gnt_idx : id_q;
        rsp_valid_d = s1_vld_q ? N_REQ'(1) << id_q : '0;
        rsp_data_d  = s1_vld_q ? prod : rsp_data_q;
        cnt_d       = cnt_q + 16'(accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= IW'(N_REQ - 1);
            s1_vld_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_vld_q    <= s1_vld_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = s1_vld_q | (|rsp_valid_q);
    assign op_count  = cnt_q;
endmodule

// File: tb/tb_fmul_arbiter.sv
// tb_fmul_arbiter: vector table and scoreboard bench for fmul_arbiter.
module tb_fmul_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready, rsp_valid;
    logic [127:0] req_a, req_b;
    logic [31:0]  rsp_data;
    logic         busy;
    logic [15:0]  op_count;

    always #5 clk = ~clk;

    fmul_arbiter #(.BIT_W(32), .N_REQ(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .op_count(op_count)
    );

    typedef struct {int due; logic [3:0] oh; logic [31:0] data;} exp_t;
    typedef struct {logic [31:0] a, b, p;} vec_t;

    exp_t        q[$];
    vec_t        vt[14];
    int          checks = 0, errors = 0, cyc = 0, mptr = 3;
    bit          mon_en = 1'b0;
    logic [15:0] mcnt = '0;
    logic [31:0] eprod[4];
    logic [3:0]  last_rdy;
    logic [31:0] held;
    logic [3:0]  order[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit busy_model();
        foreach (q[i]) if (q[i].due == cyc || q[i].due == cyc + 1) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst) chk("busy", 32'(busy), 32'(busy_model()));
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("rsp_valid", 32'(rsp_valid), 32'(q[0].oh));
                chk("rsp_data", rsp_data, q[0].data);
                q.delete(0);
            end else begin
                chk("rsp_idle", 32'(rsp_valid), 32'h0);
            end
        end
    end

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        eprod[r] = p;
    endtask

    task automatic step(input logic [3:0] v);
        int   g;
        exp_t e;
        logic [3:0] oh;
        req_valid = v;
        #1;
        g = -1;
        for (int k = 1; k <= 4; k++) if (g < 0 && v[(mptr + k) % 4]) g = (mptr + k) % 4;
        oh = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("req_ready", 32'(req_ready), 32'(oh));
        chk("op_count", 32'(op_count), 32'(mcnt));
        last_rdy = req_ready;
        if (g >= 0) begin
            e.due = cyc + 2;
            e.oh = oh;
            e.data = eprod[g];
            q.push_back(e);
            mptr = g;
            mcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req_valid = 4'hF;
        while (q.size() > 0 && q[q.size()-1].due > cyc) q.delete(q.size() - 1);
        mptr = 3;
        mcnt = '0;
        repeat (n) begin
            #1;
            chk("rst_ready", 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        req_valid = 4'h0;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
    endtask

    initial begin
        vt[0]  = '{32'h40C00000, 32'h40E00000, 32'h42280000};
        vt[1]  = '{32'h40000000, 32'h3F800000, 32'h40000000};
        vt[2]  = '{32'h40000000, 32'h40000000, 32'h40800000};
        vt[3]  = '{32'h40000000, 32'h40400000, 32'h40C00000};
        vt[4]  = '{32'h40000000, 32'h40800000, 32'h41000000};
        vt[5]  = '{32'hBFC00000, 32'h40000000, 32'hC0400000};
        vt[6]  = '{32'h00000000, 32'h40A00000, 32'h00000000};
        vt[7]  = '{32'h7F800000, 32'h40000000, 32'h7F800000};
        vt[8]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
        vt[9]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
        vt[10] = '{32'h3F000000, 32'h3E800000, 32'h3E000000};
        vt[11] = '{32'hC0000000, 32'hC0000000, 32'h40800000};
        vt[12] = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
        vt[13] = '{32'h3F800001, 32'h3F800001, 32'h3F800002};
        order  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        @(posedge clk);
        #1;
        do_reset(3);
        mon_en = 1'b1;

        set_op(0, 32'h40C00000, 32'h40E00000, 32'h42280000);
        step(4'b0001);
        chk("single_grant", 32'(last_rdy), 32'h1);
        step(4'b0000);
        step(4'b0000);
        chk("single_count", 32'(op_count), 32'h1);

        for (int i = 0; i < 14; i++) begin
            set_op(i % 4, vt[i].a, vt[i].b, vt[i].p);
            step(4'(1 << (i % 4)));
        end
        repeat (3) step(4'b0000);

        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            set_op(i, 32'h40000000, vt[i+1].b, vt[i+1].p);
        end
        for (int i = 0; i < 8; i++) begin
            step(4'hF);
            chk("contend_order", 32'(last_rdy), 32'(order[i]));
        end
        repeat (3) step(4'b0000);

        do_reset(2);
        step(4'b0001);
        step(4'b1001);
        chk("fair_skip", 32'(last_rdy), 32'b1000);
        step(4'b1001);
        chk("fair_wrap", 32'(last_rdy), 32'b0001);
        repeat (3) step(4'b0000);

        held = rsp_data;
        repeat (10) begin
            step(4'b0000);
            chk("idle_data", rsp_data, held);
            chk("idle_busy", 32'(busy), 32'h0);
        end

        set_op(1, 32'h40C00000, 32'h40E00000, 32'h42280000);
        step(4'b0010);
        do_reset(2);
        repeat (3) step(4'b0000);

        set_op(0, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        repeat (65535) step(4'b0001);
        chk("cnt_ffff", 32'(op_count), 32'hFFFF);
        step(4'b0001);
        chk("cnt_wrap", 32'(op_count), 32'h0);
        repeat (4) step(4'b0000);
        chk("sb_empty", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 Parameter: BIT_W, 32, operand/result width (IEEE-754 single).
REQ-002 Parameter: N_REQ, 4, number of requesters (2..8).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  input  N_REQ  per-requester operand-pair valid.
REQ-006 Port: req_ready  output  N_REQ  per-requester grant/accept, at most one bit set.
REQ-007 Port: req_a  input  N_REQ*BIT_W  operand A; requester i at bits [i*BIT_W +: BIT_W].
REQ-008 Port: req_b  input  N_REQ*BIT_W  operand B; same packing as req_a.
REQ-009 Port: rsp_valid  output  N_REQ  one-hot result strobe to owning requester.
REQ-010 Port: rsp_data  output  BIT_W  product, shared by all requesters.
REQ-011 Port: busy  output  1  high while any accepted operation is in flight.
REQ-012 Port: op_count  output  16  count of accepted operations, wraps modulo 2^16.

Function
REQ-013 Block SHALL instantiate exactly one existing combinational fmul (ports a_in, b_in, result) and share it among all requesters.
REQ-014 Accept: transfer for requester i occurs in cycle T when req_valid[i] & req_ready[i].
REQ-015 req_ready SHALL be combinational from req_valid and the round-robin pointer; req_ready[i] SHALL never be high unless req_valid[i] is high.
REQ-016 Arbitration SHALL be round-robin: highest priority is index (ptr+1) mod N_REQ, ascending with wrap-around; ptr holds the last granted index.
REQ-017 ptr SHALL update to the granted index only on an accept cycle; ptr SHALL hold when no req_valid is set.
REQ-018 Stage 1: on accept, operands and requester index SHALL be captured into registers a_q, b_q, id_q, with stage-1 valid set; stage-1 valid SHALL clear on cycles without accept.
REQ-019 Stage 2: fmul SHALL compute from a_q/b_q; result SHALL be registered into rsp_data, with rsp_valid = onehot(id_q) when stage-1 valid, else all zeros.
REQ-020 Latency: accept in cycle T -> rsp_valid asserted during cycle T+2 only (one-cycle pulse).
REQ-021 Throughput: one accept per cycle sustained; no bubbles under continuous requests.
REQ-022 No response backpressure; requesters SHALL consume rsp_data in the cycle rsp_valid is high.
REQ-023 rsp_data SHALL hold its last value when rsp_valid is zero.
REQ-024 busy = stage-1 valid OR stage-2 valid (registered rsp_valid nonzero).
REQ-025 op_count SHALL increment by 1 per accept; 0xFFFF + 1 -> 0x0000.
REQ-026 Requester deasserting req_valid without an accept SHALL cause no state change.
REQ-027 Arithmetic (rounding, specials) is entirely that of fmul; the arbiter SHALL not modify operands or result.

Reset
REQ-028 While rst is high at a clock edge: req_ready-driving ptr = N_REQ-1 (requester 0 wins first), stage-1 valid = 0, rsp_valid = 0, rsp_data = 0, op_count = 0, busy = 0.
REQ-029 Reset mid-operation SHALL drop all in-flight operations; no rsp_valid pulse for them after reset releases.
REQ-030 During reset cycles req_ready SHALL be all zeros; no accept occurs.

Verification
REQ-031 Single op: after reset, req_valid=0001, a=0x40C00000 (6.0), b=0x40E00000 (7.0) in cycle T -> req_ready=0001 in T; rsp_valid=0001, rsp_data=0x42280000 (42.0) in T+2; op_count=1.
REQ-032 Contention: all four valid continuously, requester i operands a=0x40000000 (2.0), b=i+1 as float -> grant order 0,1,2,3,0...; rsp_valid 0001,0010,0100,1000 in consecutive cycles from T+2; rsp_data 0x40000000,0x40800000,0x40C00000,0x41000000.
REQ-033 Fairness skip: ptr=0, req_valid=1001 -> grant 3 (not 0); next cycle with 1001 -> grant 0.
REQ-034 Reset mid-flight: accept in T, rst high in T+1 -> no rsp_valid in T+2; busy=0 and op_count=0 after reset.
REQ-035 Wrap: preload 65535 accepts (or force), one more accept -> op_count=0x0000.
REQ-036 Idle: req_valid=0 for 10 cycles -> req_ready=0, rsp_valid=0, rsp_data unchanged, busy=0.
